// File: rtl/mcs4_cycle_seq.sv
// MCS-4 instruction-cycle sequencer: steps A1..X3 on each PHI2 tick, drives SYNC,
// and provides run/halt/single-step control plus the CPU reset stretch.
module mcs4_cycle_seq #(
    parameter int RESET_CYCLES = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             phi1_i,
    input  logic             phi2_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             soft_reset_i,
    output logic             sync_o,
    output logic [2:0]       phase_o,
    output logic             halted_o,
    output logic             cycle_start_o,
    output logic             cpu_reset_o,
    output logic [CNT_W-1:0] icount_o
);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [3:0] {
        A1   = 4'd0,
        A2   = 4'd1,
        A3   = 4'd2,
        M1   = 4'd3,
        M2   = 4'd4,
        X1   = 4'd5,
        X2   = 4'd6,
        X3   = 4'd7,
        HALT = 4'd8
    } state_t;

    state_t          state;
    state_t          nxt;
    logic            phi2_q;
    logic            tick;
    logic            halt_cond;
    logic            a1_entry;
    logic            step_pend;
    logic [RC_W-1:0] rst_cnt;

    // PHI1 is carried for monitoring only; sequencing is driven by PHI2 alone.
    logic unused_phi1;
    assign unused_phi1 = phi1_i;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        tick      = phi2_i & ~phi2_q;
        halt_cond = ~cpu_reset_o & ~run_i & ~step_pend;
        nxt       = state;
        if (tick) begin
            case (state)
                X3:      nxt = halt_cond ? HALT : A1;
                HALT:    nxt = (run_i | step_pend | cpu_reset_o) ? X3 : HALT;
                default: nxt = state_t'(state + 4'd1);
            endcase
        end
        a1_entry = tick & (state == X3) & ~halt_cond;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= X3;
            phi2_q        <= 1'b1;
            step_pend     <= 1'b0;
            rst_cnt       <= RC_W'(RESET_CYCLES);
            cpu_reset_o   <= 1'b1;
            icount_o      <= '0;
            sync_o        <= 1'b0;
            phase_o       <= 3'd7;
            halted_o      <= 1'b0;
            cycle_start_o <= 1'b0;
        end else begin
            phi2_q        <= phi2_i;
            state         <= nxt;
            phase_o       <= (nxt == HALT) ? 3'd7 : nxt[2:0];
            sync_o        <= (nxt != X3);
            halted_o      <= (nxt == HALT);
            cycle_start_o <= a1_entry;

            // A step request arriving on the tick that enters HALT must not be lost.
            if (a1_entry)
                step_pend <= 1'b0;
            else if (step_i && (halted_o || (tick && state == X3 && halt_cond)))
                step_pend <= 1'b1;

            if (soft_reset_i) begin
                cpu_reset_o <= 1'b1;
                rst_cnt     <= RC_W'(RESET_CYCLES);
            end else if (a1_entry && cpu_reset_o) begin
                rst_cnt <= rst_cnt - RC_W'(1);
                if (rst_cnt == RC_W'(1))
                    cpu_reset_o <= 1'b0;
            end

            if (a1_entry && !cpu_reset_o)
                icount_o <= icount_o + CNT_W'(1);
        end
    end

endmodule
